// File: rtl/wb_stage.sv
// RV32I writeback: load extract/extend, writeback mux, retire counters, misaligned-load trap.
// Latency: rf_* outputs are combinational (0 cycles), state updates on the next edge; no backpressure.
module wb_stage #(
  parameter int          XLEN           = 32,
  parameter logic [31:0] RESET_PC_DUMMY = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu,
  input  logic [2:0]      LDSel,
  input  logic [1:0]      WBSel,
  input  logic            RegWen,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            cnt_rst,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_pc,
  output logic [XLEN-1:0] wb_pc_dbg
);

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;
  localparam logic [2:0] LD_LHU = 3'd5;

  logic [1:0]      off;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      rd;
  logic            misaligned;
  logic            retire;
  logic            unused_inst;

  logic [XLEN-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] mpc_q, mpc_d;
  logic [XLEN-1:0] dbg_q, dbg_d;

  assign off         = alu[1:0];
  assign rd          = inst[11:7];
  assign unused_inst = ^{inst[31:12], inst[6:0]};
  assign byte_v      = dmem_rdata[8*off +: 8];
  assign half_v      = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (LDSel)
      LD_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      LD_LH:   ld_data = {{16{half_v[15]}}, half_v};
      LD_LW:   ld_data = dmem_rdata;
      LD_LBU:  ld_data = {24'h0, byte_v};
      LD_LHU:  ld_data = {16'h0, half_v};
      default: ld_data = '0;
    endcase
  end

  // Only loads can be misaligned; the address bits are ignored for other sources.
  assign misaligned = (WBSel == 2'd0) &&
                      ((((LDSel == LD_LH) || (LDSel == LD_LHU)) && off[0]) ||
                       ((LDSel == LD_LW) && (off != 2'b00)));
  assign retire     = wb_valid && !misaligned;

  always_comb begin
    rf_wdata = '0;
    case (WBSel)
      2'd0:    rf_wdata = ld_data;
      2'd1:    rf_wdata = alu;
      2'd2:    rf_wdata = pc + 32'd4;
      default: rf_wdata = '0;
    endcase
  end

  assign rf_waddr = rd;
  assign rf_we    = rst_n && retire && RegWen && (rd != 5'd0);

  assign cycle_d   = cnt_rst ? '0 : cycle_q + 32'd1;
  assign instret_d = cnt_rst ? '0 : instret_q + {31'd0, retire};
  assign err_d     = err_q || (wb_valid && misaligned);
  assign mpc_d     = (!err_q && wb_valid && misaligned) ? pc : mpc_q;
  assign dbg_d     = retire ? pc : dbg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
      mpc_q     <= '0;
      dbg_q     <= RESET_PC_DUMMY;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      mpc_q     <= mpc_d;
      dbg_q     <= dbg_d;
    end
  end

  assign cycle_cnt    = cycle_q;
  assign instret_cnt  = instret_q;
  assign misalign_err = err_q;
  assign misalign_pc  = mpc_q;
  assign wb_pc_dbg    = dbg_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues hand-computed expectations, negedge monitor compares.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [31:0] pc, alu, inst, dmem_rdata;
  logic [2:0]  LDSel;
  logic [1:0]  WBSel;
  logic        RegWen, cnt_rst;
  logic        rf_we, misalign_err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, cycle_cnt, instret_cnt, misalign_pc, wb_pc_dbg;

  typedef struct {
    string       nm;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd, cyc, ins;
    logic        err;
    logic [31:0] mpc, dbg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wb_stage #(.XLEN(32), .RESET_PC_DUMMY(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .pc(pc), .alu(alu),
    .LDSel(LDSel), .WBSel(WBSel), .RegWen(RegWen), .inst(inst),
    .dmem_rdata(dmem_rdata), .cnt_rst(cnt_rst), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt), .misalign_err(misalign_err),
    .misalign_pc(misalign_pc), .wb_pc_dbg(wb_pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.nm, "rf_we",    {31'd0, rf_we},        {31'd0, e.we});
      cmp(e.nm, "rf_waddr", {27'd0, rf_waddr},     {27'd0, e.wa});
      cmp(e.nm, "rf_wdata", rf_wdata,              e.wd);
      cmp(e.nm, "cycle",    cycle_cnt,             e.cyc);
      cmp(e.nm, "instret",  instret_cnt,           e.ins);
      cmp(e.nm, "err",      {31'd0, misalign_err}, {31'd0, e.err});
      cmp(e.nm, "mpc",      misalign_pc,           e.mpc);
      cmp(e.nm, "dbg",      wb_pc_dbg,             e.dbg);
    end
  end

  task automatic set_in(input logic v, input logic [31:0] p, input logic [31:0] a,
                        input logic [2:0] ld, input logic [1:0] ws, input logic re,
                        input logic [4:0] rd, input logic cr);
    wb_valid = v; pc = p; alu = a; LDSel = ld; WBSel = ws; RegWen = re;
    inst = {20'h0, rd, 7'h6f}; cnt_rst = cr;
  endtask

  task automatic expect_st(input string nm, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [31:0] cyc, input logic [31:0] ins,
                           input logic err, input logic [31:0] mpc, input logic [31:0] dbg);
    exp_t e;
    e.nm = nm; e.we = we; e.wa = wa; e.wd = wd; e.cyc = cyc; e.ins = ins;
    e.err = err; e.mpc = mpc; e.dbg = dbg;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs just after an edge; the expected counters are those produced by that edge.
  task automatic step(input string nm, input logic v, input logic [31:0] p, input logic [31:0] a,
                      input logic [2:0] ld, input logic [1:0] ws, input logic re, input logic [4:0] rd,
                      input logic cr, input logic ewe, input logic [31:0] ewd, input logic [31:0] ecyc,
                      input logic [31:0] eins, input logic eerr, input logic [31:0] empc,
                      input logic [31:0] edbg);
    @(posedge clk);
    #1;
    set_in(v, p, a, ld, ws, re, rd, cr);
    expect_st(nm, ewe, rd, ewd, ecyc, eins, eerr, empc, edbg);
  endtask

  initial begin
    dmem_rdata = 32'h8081_F27F;
    rst_n = 1'b0;
    set_in(1'b1, 32'h0, 32'h55, 3'd2, 2'd1, 1'b1, 5'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_st("reset", 1'b0, 5'd5, 32'h55, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0);

    for (int i = 1; i <= 10; i++)
      step("idle", 1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0,
           1'b0, 32'h0, i, 0, 1'b0, 0, 0);

    //   name        v     pc            alu           ld    ws    re    rd     cr    we    wdata         cyc  ins err mpc           dbg
    step("lb_off1",  1'b1, 32'h0000_0100, 32'h0000_0401, 3'd0, 2'd0, 1'b1, 5'd2,  1'b0, 1'b1, 32'hFFFF_FFF2, 11, 0, 1'b0, 0,            32'h0);
    step("lbu_off3", 1'b1, 32'h0000_0104, 32'h0000_0403, 3'd4, 2'd0, 1'b1, 5'd3,  1'b0, 1'b1, 32'h0000_0080, 12, 1, 1'b0, 0,            32'h100);
    step("lh_off2",  1'b1, 32'h0000_0108, 32'h0000_0402, 3'd1, 2'd0, 1'b1, 5'd4,  1'b0, 1'b1, 32'hFFFF_8081, 13, 2, 1'b0, 0,            32'h104);
    step("lhu_off0", 1'b1, 32'h0000_010C, 32'h0000_0400, 3'd5, 2'd0, 1'b1, 5'd5,  1'b0, 1'b1, 32'h0000_F27F, 14, 3, 1'b0, 0,            32'h108);
    step("lw_off0",  1'b1, 32'h0000_0110, 32'h0000_0400, 3'd2, 2'd0, 1'b1, 5'd6,  1'b0, 1'b1, 32'h8081_F27F, 15, 4, 1'b0, 0,            32'h10C);
    step("jal_rd1",  1'b1, 32'h0000_1000, 32'h0000_2000, 3'd2, 2'd2, 1'b1, 5'd1,  1'b0, 1'b1, 32'h0000_1004, 16, 5, 1'b0, 0,            32'h110);
    step("jal_rd0",  1'b1, 32'h0000_1000, 32'h0000_2000, 3'd2, 2'd2, 1'b1, 5'd0,  1'b0, 1'b0, 32'h0000_1004, 17, 6, 1'b0, 0,            32'h1000);
    step("lw_mis",   1'b1, 32'h0000_2000, 32'h0000_0102, 3'd2, 2'd0, 1'b1, 5'd7,  1'b0, 1'b0, 32'h8081_F27F, 18, 7, 1'b0, 0,            32'h1000);
    step("lh_mis2",  1'b1, 32'h0000_3000, 32'h0000_0001, 3'd1, 2'd0, 1'b1, 5'd8,  1'b0, 1'b0, 32'hFFFF_F27F, 19, 7, 1'b1, 32'h0000_2000, 32'h1000);
    step("cnt_rst",  1'b1, 32'h0000_1F00, 32'hDEAD_BEEF, 3'd2, 2'd1, 1'b1, 5'd9,  1'b1, 1'b1, 32'hDEAD_BEEF, 20, 7, 1'b1, 32'h0000_2000, 32'h1000);
    step("ret1",     1'b1, 32'h0000_4000, 32'h0000_0011, 3'd2, 2'd1, 1'b1, 5'd10, 1'b0, 1'b1, 32'h0000_0011, 0,  0, 1'b1, 32'h0000_2000, 32'h1F00);
    step("ret2",     1'b1, 32'h0000_4004, 32'h0000_0022, 3'd2, 2'd1, 1'b1, 5'd11, 1'b0, 1'b1, 32'h0000_0022, 1,  1, 1'b1, 32'h0000_2000, 32'h4000);
    step("ret3",     1'b1, 32'h0000_4008, 32'h0000_0033, 3'd2, 2'd1, 1'b1, 5'd12, 1'b0, 1'b1, 32'h0000_0033, 2,  2, 1'b1, 32'h0000_2000, 32'h4004);
    step("wbs3_bub", 1'b0, 32'h0000_4100, 32'h0000_0044, 3'd2, 2'd3, 1'b1, 5'd13, 1'b0, 1'b0, 32'h0000_0000, 3,  3, 1'b1, 32'h0000_2000, 32'h4008);
    step("ld_resv",  1'b1, 32'h0000_5000, 32'h0000_0000, 3'd3, 2'd0, 1'b1, 5'd14, 1'b0, 1'b1, 32'h0000_0000, 4,  3, 1'b1, 32'h0000_2000, 32'h4008);
    step("pc4_wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 3'd2, 2'd2, 1'b1, 5'd15, 1'b0, 1'b1, 32'h0000_0000, 5,  4, 1'b1, 32'h0000_2000, 32'h5000);
    step("bub",      1'b0, 32'h0000_0000, 32'h0000_0000, 3'd2, 2'd1, 1'b1, 5'd3,  1'b0, 1'b0, 32'h0000_0000, 6,  5, 1'b1, 32'h0000_2000, 32'hFFFF_FFFC);
    step("pre_wrap", 1'b0, 32'h0000_0000, 32'h0000_0000, 3'd2, 2'd1, 1'b1, 5'd3,  1'b0, 1'b0, 32'h0000_0000, 7,  5, 1'b1, 32'h0000_2000, 32'hFFFF_FFFC);

    // Backdoor the next-state so the following edge lands the counter at FFFF_FFFE.
    @(negedge clk);
    #1;
    force dut.cycle_d = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.cycle_d;
    expect_st("preload", 1'b0, 5'd3, 32'h0, 32'hFFFF_FFFE, 5, 1'b1, 32'h0000_2000, 32'hFFFF_FFFC);
    step("wrap1", 1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0,
         1'b0, 32'h0, 32'hFFFF_FFFF, 5, 1'b1, 32'h0000_2000, 32'hFFFF_FFFC);
    step("wrap0", 1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0,
         1'b0, 32'h0, 32'h0, 5, 1'b1, 32'h0000_2000, 32'hFFFF_FFFC);

    // Mid-cycle async reset: the negedge monitor samples before any rising edge.
    @(posedge clk);
    #1;
    set_in(1'b1, 32'h0000_6000, 32'h77, 3'd2, 2'd1, 1'b1, 5'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    expect_st("async_rst", 1'b0, 5'd5, 32'h77, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0);
    step("post_rst", 1'b0, 32'h0, 32'h0, 3'd2, 2'd1, 1'b1, 5'd3, 1'b0,
         1'b0, 32'h0, 1, 0, 1'b0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
